// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 8N1 UART receiver feeding a first-word-fall-through byte FIFO,
//            with sticky overrun / framing-error flags.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  uart_rxd,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    output logic                  frame_err,
    input  logic                  clr_err
);

    localparam int                DIV        = CLK_HZ / BAUD;
    localparam int                CNT_W      = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0]  DIV_RELOAD = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  DIV_HALF   = CNT_W'(DIV / 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             sync_q, sync_d;
    logic [CNT_W-1:0]       baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   push_q, push_d;
    logic [7:0]             push_data_q, push_data_d;
    logic [DEPTH_LOG2:0]    wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]    rd_ptr_q, rd_ptr_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;
    logic [7:0]             mem [2**DEPTH_LOG2];

    logic w_rx, w_fall, w_expire, w_fe_set;
    logic w_full, w_empty, w_pop, w_wr, w_ovf_set;

    // sync_q[1] is the resynchronised line; sync_q[2] is its one-cycle-old copy
    always_comb begin
        sync_d   = {sync_q[1:0], uart_rxd};
        w_rx     = sync_q[1];
        w_fall   = sync_q[2] & ~sync_q[1];
        w_expire = (baud_q == '0);

        state_d     = state_q;
        baud_d      = w_expire ? baud_q : baud_q - 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        w_fe_set    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_fall) begin
                    baud_d  = DIV_HALF;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_expire) begin
                    if (!w_rx) begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                        baud_d  = DIV_RELOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_expire) begin
                    shift_d = {w_rx, shift_q[7:1]};
                    baud_d  = DIV_RELOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_expire) begin
                    if (w_rx) begin
                        push_d      = 1'b1;
                        push_data_d = shift_q;
                        state_d     = S_IDLE;
                    end else begin
                        w_fe_set = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (w_rx) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A simultaneous pop frees the slot being written, so a full FIFO still accepts
    always_comb begin
        w_empty   = (wr_ptr_q == rd_ptr_q);
        w_full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                    (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
        w_pop     = rd_en & ~w_empty;
        w_wr      = push_q & (~w_full | w_pop);
        w_ovf_set = push_q & w_full & ~w_pop;

        wr_ptr_d    = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, w_wr};
        rd_ptr_d    = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, w_pop};
        overrun_d   = w_ovf_set | (overrun_q & ~clr_err);
        frame_err_d = w_fe_set | (frame_err_q & ~clr_err);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            sync_q      <= 3'b111;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            push_q      <= 1'b0;
            push_data_q <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data_q;
        end
    end

    assign count     = wr_ptr_q - rd_ptr_q;
    assign rd_valid  = ~w_empty;
    assign rd_data   = w_empty ? 8'h00 : mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Scoreboard bench for uart_rx_fifo at a reduced baud divisor (32).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CLK_HZ     = 3200000;
    localparam int BAUD       = 100000;
    localparam int DEPTH_LOG2 = 4;
    localparam int DIV        = CLK_HZ / BAUD;
    localparam int LAT        = (19 * DIV) / 2 + 4;

    logic                 sys_clk;
    logic                 sys_rst;
    logic                 uart_rxd;
    logic                 rd_en;
    logic                 clr_err;
    logic [7:0]           rd_data;
    logic                 rd_valid;
    logic [DEPTH_LOG2:0]  count;
    logic                 overrun;
    logic                 frame_err;

    int        n_checks = 0;
    int        n_errors = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .uart_rxd  (uart_rxd),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        uart_rxd = 1'b0;
        wait_cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            wait_cyc(DIV);
        end
        uart_rxd = stop_bit;
        wait_cyc(DIV);
        uart_rxd = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {24'd0, rd_data}, {24'd0, e});
        end
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
    endtask

    initial begin
        int n;
        sys_rst  = 1'b1;
        uart_rxd = 1'b1;
        rd_en    = 1'b0;
        clr_err  = 1'b0;
        wait_cyc(3);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_data", {24'd0, rd_data}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_fe", {31'd0, frame_err}, 32'd0);
        sys_rst = 1'b0;
        wait_cyc(4);

        // Single byte and its latency from the start edge
        exp_q.push_back(8'h55);
        n = 0;
        fork
            send_byte(8'h55, 1'b1);
            begin
                while (!rd_valid && n < 2000) begin
                    wait_cyc(1);
                    n++;
                end
            end
        join
        check("lat_window", {31'd0, (n >= LAT - 8) && (n <= LAT + 8)}, 32'd1);
        check("one_count", {27'd0, count}, 32'd1);
        pop_check("one_data");
        check("one_empty", {31'd0, rd_valid}, 32'd0);
        check("one_count0", {27'd0, count}, 32'd0);

        // 17 back-to-back frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        wait_cyc(DIV);
        check("full_count", {27'd0, count}, 32'd16);
        check("full_ovr", {31'd0, overrun}, 32'd1);
        check("full_fe", {31'd0, frame_err}, 32'd0);
        for (int i = 0; i < 16; i++) pop_check("drain");
        check("drain_empty", {31'd0, rd_valid}, 32'd0);

        // Pop coinciding with a push into a full FIFO
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        check("clr_ovr", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h20 + 8'(i));
            send_byte(8'h20 + 8'(i), 1'b1);
        end
        wait_cyc(DIV);
        check("refill_count", {27'd0, count}, 32'd16);
        exp_q.push_back(8'hA5);
        fork
            send_byte(8'hA5, 1'b1);
            begin
                wait_cyc(LAT);
                pop_check("coinc_pop");
            end
        join
        wait_cyc(DIV);
        check("coinc_count", {27'd0, count}, 32'd16);
        check("coinc_ovr", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 16; i++) pop_check("coinc_drain");
        check("coinc_empty", {31'd0, rd_valid}, 32'd0);

        // Framing error followed by a long break
        send_byte(8'h3C, 1'b0);
        uart_rxd = 1'b0;
        wait_cyc(20 * DIV);
        uart_rxd = 1'b1;
        wait_cyc(2 * DIV);
        check("fe_set", {31'd0, frame_err}, 32'd1);
        check("fe_count", {27'd0, count}, 32'd0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        wait_cyc(DIV);
        check("fe_next_count", {27'd0, count}, 32'd1);
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        check("fe_clr", {31'd0, frame_err}, 32'd0);
        pop_check("fe_next_data");

        // Short low glitch on an idle line
        uart_rxd = 1'b0;
        wait_cyc(DIV / 4);
        uart_rxd = 1'b1;
        wait_cyc(12 * DIV);
        check("glitch_count", {27'd0, count}, 32'd0);
        check("glitch_ovr", {31'd0, overrun}, 32'd0);
        check("glitch_fe", {31'd0, frame_err}, 32'd0);

        // Asynchronous reset in the middle of a frame, with a byte already buffered
        send_byte(8'h77, 1'b1);
        wait_cyc(DIV);
        check("prerst_count", {27'd0, count}, 32'd1);
        exp_q.delete();
        fork
            send_byte(8'hF0, 1'b1);
            begin
                wait_cyc(5 * DIV + DIV / 2);
                #2;
                sys_rst = 1'b1;
                #1;
                check("arst_valid", {31'd0, rd_valid}, 32'd0);
                check("arst_count", {27'd0, count}, 32'd0);
                check("arst_data", {24'd0, rd_data}, 32'd0);
                wait_cyc(3);
                sys_rst = 1'b0;
            end
        join
        wait_cyc(2 * DIV);
        check("postrst_count", {27'd0, count}, 32'd0);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1);
        wait_cyc(DIV);
        check("postrst_count1", {27'd0, count}, 32'd1);
        pop_check("postrst_data");
        check("postrst_sb", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
